// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract accumulator slice.
package addsub_pkg;

  localparam int unsigned TERM_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/addsub_term_decode.sv
// Maps a raw 2-bit adder/subtractor result plus carry/borrow to a signed term.
module addsub_term_decode
  import addsub_pkg::*;
(
  input  logic                     mode,
  input  logic                     cbout,
  input  logic [1:0]               sum,
  output logic signed [TERM_W-1:0] term
);

  // A subtract borrow means the true result is sum-4, i.e. sum with ones above it.
  always_comb begin
    if (mode) begin
      term = {{(TERM_W-2){cbout}}, sum};
    end else begin
      term = {{(TERM_W-3){1'b0}}, cbout, sum};
    end
  end

endmodule

// File: rtl/addsub_accumulator.sv
// Accumulates MAX_OPS signed add/subtract results into a saturating total.
module addsub_accumulator
  import addsub_pkg::*;
#(
  parameter  int unsigned ACC_W   = 8,
  parameter  int unsigned MAX_OPS = 16,
  localparam int unsigned CNT_W   = $clog2(MAX_OPS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic [1:0]       sum,
  input  logic             cbout,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] op_count,
  output logic             sat,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t                     state_q, state_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       sat_q, sat_d;
  logic signed [TERM_W-1:0]   term;
  logic [ACC_W:0]             wide;
  logic                       ovf;
  logic [ACC_W-1:0]           clamp_val;
  logic                       last_op;

  addsub_term_decode u_decode (
    .mode  (mode),
    .cbout (cbout),
    .sum   (sum),
    .term  (term)
  );

  // One guard bit: overflow when the two top bits of the sign-extended sum differ.
  always_comb begin
    wide      = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-TERM_W){term[TERM_W-1]}}, term};
    ovf       = wide[ACC_W] ^ wide[ACC_W-1];
    clamp_val = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    last_op   = (cnt_q == CNT_W'(MAX_OPS - 1));
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_d = ovf ? clamp_val : wide[ACC_W-1:0];
            sat_d = sat_q | ovf;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_op) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign acc       = acc_q;
  assign op_count  = cnt_q;
  assign sat       = sat_q;

endmodule

// File: doc/addsub_accumulator.md
ADDSUB_ACCUMULATOR -- requirements
Module: addsub_accumulator

Interface
REQ-001 Parameter: ACC_W, default 8, width of the signed running total (two's complement, minimum 4).
REQ-002 Parameter: MAX_OPS, default 16, number of results accepted per accumulation run (minimum 1).
REQ-003 Clocking: one clock, clk; reset is reset, synchronous and active-high.
REQ-004 Port: clk  input  1  system clock, all state updates on its rising edge.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: start  input  1  single-cycle pulse that begins a run.
REQ-007 Port: clear  input  1  synchronous abort; returns the block to idle.
REQ-008 Port: sum  input  2  low result bits from the upstream 2-bit adder/subtractor.
REQ-009 Port: cbout  input  1  upstream carry (add mode) or borrow (subtract mode).
REQ-010 Port: mode  input  1  0 = add, 1 = subtract; the same value driven to the upstream stage.
REQ-011 Port: in_valid  input  1  sum, cbout and mode hold a valid result.
REQ-012 Port: in_ready  output  1  the block accepts a result this cycle.
REQ-013 Port: acc  output  ACC_W  signed running total.
REQ-014 Port: op_count  output  clog2(MAX_OPS+1)  number of results accepted in the current run.
REQ-015 Port: sat  output  1  sticky flag, set when any update in the run saturated.
REQ-016 Port: out_valid  output  1  the run is complete and acc is final.
REQ-017 Port: out_ready  input  1  downstream consumes the final total.

Function
REQ-018 Term decode: mode=0 gives the unsigned term {cbout,sum} (0..6).
REQ-019 Term decode: mode=1, cbout=0 gives term = sum (0..3).
REQ-020 Term decode: mode=1, cbout=1 gives term = sum - 4 (-3..-1).
REQ-021 FSM states are IDLE, ACCUM and DONE.
REQ-022 IDLE: in_ready=0 and out_valid=0; start moves the FSM to ACCUM, clears acc, op_count and sat in the same edge.
REQ-023 ACCUM: in_ready=1; a transfer occurs only when in_valid and in_ready are both 1.
REQ-024 Each transfer registers acc <= sat_add(acc, term) and op_count <= op_count+1; both are visible the next cycle (latency 1).
REQ-025 sat_add clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1) on overflow and sets sat; sat stays set until the next start, clear or reset.
REQ-026 The transfer that makes op_count equal MAX_OPS moves the FSM to DONE in the same edge.
REQ-027 DONE: out_valid=1 and in_ready=0; acc, op_count and sat hold their values.
REQ-028 DONE: out_ready=1 returns the FSM to IDLE and leaves acc held; out_valid holds indefinitely while out_ready=0.
REQ-029 start is ignored in ACCUM and DONE.
REQ-030 in_valid is ignored outside ACCUM.
REQ-031 clear in any state forces IDLE and zeroes acc, op_count and sat on the next edge.
REQ-032 clear has priority over start, transfers and out_ready when they coincide.
REQ-033 With MAX_OPS=1, a single transfer goes ACCUM->DONE.

Reset
REQ-034 Reset forces state=IDLE, acc=0, op_count=0, sat=0, in_ready=0, out_valid=0.
REQ-035 Reset has priority over clear and all other inputs, including mid-run and in DONE.

Structure
REQ-036 Package addsub_pkg shall hold the FSM state enum (IDLE, ACCUM, DONE) and the constant TERM_W=4.
REQ-037 Sub-module addsub_term_decode shall be purely combinational, mapping {mode,cbout,sum} to a signed TERM_W term per REQ-018 to REQ-020.
REQ-038 All other logic shall reside in addsub_accumulator.

Verification
REQ-039 Reset then start, feed 16 add results of sum=2'b11, cbout=1 (term 7? no: 6 is max, use sum=2'b10, cbout=1, term 6) -> acc=96, op_count=16, sat=0, out_valid=1.
REQ-040 Start, feed 16 subtract results of sum=2'b01, cbout=1 (term -3) -> acc=-48, sat=0.
REQ-041 Start, feed 16 x term 6 with ACC_W=6 -> acc saturates at 31 and sat=1 in DONE.
REQ-042 Start, 5 transfers, then clear and start asserted together -> IDLE next cycle, acc=0, op_count=0.
REQ-043 Reach DONE, hold out_ready=0 for 10 cycles while toggling in_valid and start -> acc unchanged, out_valid=1; out_ready=1 -> IDLE.
REQ-044 Reset asserted mid-run with in_valid=1 -> all outputs take their REQ-034 values the next cycle and no transfer is counted.
